// File: rtl/instr_decode_ctrl_if.sv
// Fetch handshake and decoded control bundle between the fetch stage and instr_decode_ctrl.
// The decoder drives the slave side; the fetch/execute side uses the master modport.
interface instr_decode_ctrl_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        flush;

  logic        RegWrite;
  logic        ImmSel;
  logic        ALUSrc;
  logic        CompEnbl;
  logic        ShiftAmntSel;
  logic        ShiftEnbl;
  logic        ShortBr;
  logic        LongBr;
  logic        MemRead;
  logic        MemWrite;
  logic        BranchReg;
  logic [1:0]  ALUOp;
  logic [1:0]  RegDst;
  logic [1:0]  ShiftType;
  logic [1:0]  BranchType;
  logic [1:0]  JumpType;
  logic [1:0]  MemToReg;

  logic        ctrl_valid;
  logic        halted;
  logic        illegal;

  modport master (
    output instr, instr_valid, flush,
    input  instr_ready,
    input  RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl,
           ShortBr, LongBr, MemRead, MemWrite, BranchReg,
    input  ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg,
    input  ctrl_valid, halted, illegal
  );

  modport slave (
    input  instr, instr_valid, flush,
    output instr_ready,
    output RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl,
           ShortBr, LongBr, MemRead, MemWrite, BranchReg,
    output ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg,
    output ctrl_valid, halted, illegal
  );
endinterface

// File: rtl/instr_decode_ctrl.sv
// Instruction decode controller: registers a decoded control bundle per accepted instruction.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal instructions into HALT with a sticky illegal flag.
module instr_decode_ctrl (
  input  logic               clk,
  input  logic               rst,
  instr_decode_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_LOAD_WAIT = 2'd2,
    ST_HALT      = 2'd3
  } state_e;

  typedef struct packed {
    logic       reg_write;
    logic       imm_sel;
    logic       alu_src;
    logic       comp_enbl;
    logic       shift_amnt_sel;
    logic       shift_enbl;
    logic       short_br;
    logic       long_br;
    logic       mem_read;
    logic       mem_write;
    logic       branch_reg;
    logic [1:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] shift_type;
    logic [1:0] branch_type;
    logic [1:0] jump_type;
    logic [1:0] mem_to_reg;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_COMPI = 6'h02;
  localparam logic [5:0] OP_SHIFT = 6'h03;
  localparam logic [5:0] OP_LW    = 6'h04;
  localparam logic [5:0] OP_SW    = 6'h05;
  localparam logic [5:0] OP_BR    = 6'h06;
  localparam logic [5:0] OP_SBR   = 6'h07;
  localparam logic [5:0] OP_JUMP  = 6'h08;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  state_e     r_state;
  state_e     w_state_nxt;
  ctrl_t      r_ctrl;
  ctrl_t      w_ctrl_nxt;
  ctrl_t      w_dec;
  logic       r_ctrl_valid;
  logic       w_ctrl_valid_nxt;
  logic       r_run;
  logic       w_dec_illegal;
  logic       w_dec_halt;
  logic       w_dec_load;
  logic       w_ready;
  logic       w_accept;
  logic [5:0] w_opcode;
  logic [4:0] w_funct;
  logic       w_unused_bits;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       r_illegal;
  logic       w_illegal_nxt;
`endif

  assign w_opcode      = bus.instr[31:26];
  assign w_funct       = bus.instr[4:0];
  assign w_unused_bits = ^bus.instr[25:5];

  // r_run keeps the fetch port closed until the first clock edge after reset release.
  assign w_ready  = r_run && !bus.flush && ((r_state == ST_IDLE) || (r_state == ST_ISSUE));
  assign w_accept = bus.instr_valid && w_ready;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_dec         = '0;
    w_dec_illegal = 1'b0;
    w_dec_halt    = 1'b0;
    w_dec_load    = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_dec.alu_op    = 2'b10;
        w_dec.reg_write = 1'b1;
        w_dec.comp_enbl = (w_funct == 5'b00101);
      end
      OP_ADDI, OP_COMPI: begin
        w_dec.alu_src   = 1'b1;
        w_dec.alu_op    = 2'b01;
        w_dec.reg_write = 1'b1;
        w_dec.comp_enbl = (w_opcode == OP_COMPI);
      end
      OP_SHIFT: begin
        w_dec.shift_enbl     = 1'b1;
        w_dec.reg_write      = 1'b1;
        w_dec.alu_op         = 2'b01;
        w_dec.shift_type     = w_funct[1:0];
        w_dec.shift_amnt_sel = w_funct[2];
        w_dec_illegal        = (w_funct[1:0] == 2'b11);
      end
      OP_LW, OP_SW: begin
        w_dec.imm_sel    = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.alu_op     = 2'b01;
        w_dec.mem_read   = (w_opcode == OP_LW);
        w_dec.mem_write  = (w_opcode == OP_SW);
        w_dec.mem_to_reg = (w_opcode == OP_LW) ? 2'b01 : 2'b00;
        w_dec_load       = (w_opcode == OP_LW);
      end
      OP_BR: begin
        w_dec.branch_reg = 1'b1;
        w_dec.long_br    = 1'b1;
      end
      OP_SBR: begin
        w_dec.short_br    = 1'b1;
        w_dec.branch_type = w_funct[1:0];
      end
      OP_JUMP: begin
        w_dec.long_br   = 1'b1;
        w_dec.jump_type = w_funct[1:0];
        if (w_funct[1:0] == 2'b01) begin
          w_dec.reg_write  = 1'b1;
          w_dec.reg_dst    = 2'b10;
          w_dec.mem_to_reg = 2'b10;
        end
      end
      OP_HALT: w_dec_halt = 1'b1;
      default: w_dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ctrl_nxt       = '0;
    w_ctrl_valid_nxt = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    w_illegal_nxt    = r_illegal;
`endif
    case (r_state)
      ST_HALT: w_state_nxt = ST_HALT;
      ST_LOAD_WAIT: begin
        w_state_nxt = ST_IDLE;
        if (!bus.flush) begin
          // Second load cycle: same bundle, now writing the loaded value back.
          w_ctrl_nxt           = r_ctrl;
          w_ctrl_nxt.reg_write = 1'b1;
          w_ctrl_valid_nxt     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (w_dec_halt) begin
            w_state_nxt = ST_HALT;
          end else if (w_dec_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            w_illegal_nxt = 1'b1;
            w_state_nxt   = ST_HALT;
`else
            w_ctrl_valid_nxt = 1'b1;
            w_state_nxt      = ST_ISSUE;
`endif
          end else begin
            w_ctrl_nxt       = w_dec;
            w_ctrl_valid_nxt = 1'b1;
            w_state_nxt      = w_dec_load ? ST_LOAD_WAIT : ST_ISSUE;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_ctrl       <= '0;
      r_ctrl_valid <= 1'b0;
      r_run        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ctrl       <= w_ctrl_nxt;
      r_ctrl_valid <= w_ctrl_valid_nxt;
      r_run        <= 1'b1;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_illegal <= 1'b0;
    else      r_illegal <= w_illegal_nxt;
  end
  assign bus.illegal = r_illegal;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.instr_ready  = w_ready;
  assign bus.ctrl_valid   = r_ctrl_valid;
  assign bus.halted       = (r_state == ST_HALT);
  assign bus.RegWrite     = r_ctrl.reg_write;
  assign bus.ImmSel       = r_ctrl.imm_sel;
  assign bus.ALUSrc       = r_ctrl.alu_src;
  assign bus.CompEnbl     = r_ctrl.comp_enbl;
  assign bus.ShiftAmntSel = r_ctrl.shift_amnt_sel;
  assign bus.ShiftEnbl    = r_ctrl.shift_enbl;
  assign bus.ShortBr      = r_ctrl.short_br;
  assign bus.LongBr       = r_ctrl.long_br;
  assign bus.MemRead      = r_ctrl.mem_read;
  assign bus.MemWrite     = r_ctrl.mem_write;
  assign bus.BranchReg    = r_ctrl.branch_reg;
  assign bus.ALUOp        = r_ctrl.alu_op;
  assign bus.RegDst       = r_ctrl.reg_dst;
  assign bus.ShiftType    = r_ctrl.shift_type;
  assign bus.BranchType   = r_ctrl.branch_type;
  assign bus.JumpType     = r_ctrl.jump_type;
  assign bus.MemToReg     = r_ctrl.mem_to_reg;

endmodule
